// File: rtl/counter_seq_pkg.sv
// Shared types and pattern helpers for counter_sequencer.
// Pattern functions work on a PatMaxW-bit carrier; callers truncate to their own width.
package counter_seq_pkg;

  localparam int unsigned PatMaxW = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    ModeRing    = 2'b00,
    ModeJohnson = 2'b01,
    ModeBinary  = 2'b10
  } mode_t;

  function automatic logic [PatMaxW-1:0] pat_mask(int unsigned w);
    pat_mask = (w >= PatMaxW) ? '1 : ((PatMaxW'(1) << w) - PatMaxW'(1));
  endfunction

  function automatic logic [PatMaxW-1:0] pat_seed(mode_t md, int unsigned w);
    pat_seed = (md == ModeRing) ? (PatMaxW'(1) << (w - 1)) : '0;
  endfunction

  // One advance of the selected sequence; rev walks it backwards.
  function automatic logic [PatMaxW-1:0] pat_next(mode_t md, logic [PatMaxW-1:0] v,
                                                  int unsigned w, logic rev);
    logic [PatMaxW-1:0] m, x, r;
    logic lsb, msb;
    m   = pat_mask(w);
    x   = v & m;
    lsb = x[0];
    msb = x[w-1];
    case (md)
      ModeRing: begin
        // Anything that is not one-hot recovers to the seed.
        if (x == '0 || (x & (x - PatMaxW'(1))) != '0) r = pat_seed(ModeRing, w);
        else if (rev) r = ((x << 1) & m) | PatMaxW'(msb);
        else          r = (x >> 1) | (PatMaxW'(lsb) << (w - 1));
      end
      ModeJohnson: begin
        lsb = ~x[0];
        msb = ~x[w-1];
        if (rev) r = ((x << 1) & m) | PatMaxW'(msb);
        else     r = (x >> 1) | (PatMaxW'(lsb) << (w - 1));
      end
      ModeBinary: r = rev ? ((x - PatMaxW'(1)) & m) : ((x + PatMaxW'(1)) & m);
      default:    r = x;
    endcase
    pat_next = r;
  endfunction

endpackage

// File: rtl/counter_sequencer_if.sv
// Control/status bundle between button logic, counter_sequencer and the LEDs.
// COUNTER_SEQ_REVERSE_EN adds the dir signal.
interface counter_sequencer_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             start;
  logic             stop;
  logic             step;
`ifdef COUNTER_SEQ_REVERSE_EN
  logic             dir;
`endif
  logic [1:0]       mode_req;
  logic             mode_req_valid;
  logic             mode_req_ready;
  logic [WIDTH-1:0] out;
  logic [1:0]       state;
  logic             tick;
  logic             wrap;

  modport master (
    output start, stop, step,
`ifdef COUNTER_SEQ_REVERSE_EN
    output dir,
`endif
    output mode_req, mode_req_valid,
    input  mode_req_ready, out, state, tick, wrap
  );

  modport slave (
    input  start, stop, step,
`ifdef COUNTER_SEQ_REVERSE_EN
    input  dir,
`endif
    input  mode_req, mode_req_valid,
    output mode_req_ready, out, state, tick, wrap
  );
endinterface

// File: rtl/tick_prescaler.sv
// Clock-enable prescaler: term is high every DIV_MAX+1 enabled cycles; count clears when disabled.
module tick_prescaler #(
  parameter int unsigned DIV_MAX = 49_999_999
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic term
);
  localparam int unsigned CntW = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign term = en && (cnt_q == CntW'(DIV_MAX));

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (!en || term) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/counter_sequencer.sv
// Run/pause/step LED pattern sequencer with deferred mode changes.
// Define COUNTER_SEQ_REVERSE_EN to enable backward traversal via bus.dir.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned DIV_MAX = 49_999_999
) (
  input  logic                clk,
  input  logic                rst,
  counter_sequencer_if.slave  bus
);
  state_t           state_q, state_d;
  mode_t            mode_q, mode_d, pend_mode_q, pend_mode_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             tick_q, tick_d, wrap_q, wrap_d;
  logic             term, rev, advance, accept;
  logic [WIDTH-1:0] cur_seed, nxt;

  tick_prescaler #(
    .DIV_MAX (DIV_MAX)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == StRun),
    .term (term)
  );

`ifdef COUNTER_SEQ_REVERSE_EN
  assign rev = bus.dir;
`else
  assign rev = 1'b0;
`endif

  assign accept   = bus.mode_req_valid && !pend_q && (bus.mode_req != 2'b11);
  assign cur_seed = WIDTH'(pat_seed(mode_q, WIDTH));
  assign nxt      = WIDTH'(pat_next(mode_q, PatMaxW'(out_q), WIDTH, rev));

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    out_d       = out_q;
    pend_d      = pend_q;
    pend_mode_d = pend_mode_q;
    tick_d      = 1'b0;
    wrap_d      = 1'b0;
    advance     = 1'b0;

    unique case (state_q)
      StIdle, StPause: begin
        if (bus.stop) begin
          if (state_q == StPause) begin
            state_d = StIdle;
            out_d   = cur_seed;
          end
        end else if (bus.start) begin
          state_d = StRun;
        end else if (bus.step) begin
          advance = 1'b1;
        end
      end
      StRun: begin
        if (bus.stop) state_d = StPause;
        advance = term;
      end
      default: state_d = StIdle;
    endcase

    if (advance) begin
      tick_d = 1'b1;
      // A pending mode swaps in exactly where the old sequence would wrap.
      if (pend_q && (nxt == cur_seed)) begin
        mode_d = pend_mode_q;
        out_d  = WIDTH'(pat_seed(pend_mode_q, WIDTH));
        pend_d = 1'b0;
        wrap_d = 1'b1;
      end else begin
        out_d  = nxt;
        wrap_d = (nxt == cur_seed);
      end
    end

    // Request left over from RUN takes effect once we are no longer running.
    if (pend_q && state_q != StRun) begin
      mode_d = pend_mode_q;
      out_d  = WIDTH'(pat_seed(pend_mode_q, WIDTH));
      pend_d = 1'b0;
      tick_d = 1'b0;
      wrap_d = 1'b0;
    end

    if (accept) begin
      if (state_q == StRun) begin
        pend_d      = 1'b1;
        pend_mode_d = mode_t'(bus.mode_req);
      end else begin
        mode_d = mode_t'(bus.mode_req);
        out_d  = WIDTH'(pat_seed(mode_t'(bus.mode_req), WIDTH));
        tick_d = 1'b0;
        wrap_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mode_q      <= ModeRing;
      pend_q      <= 1'b0;
      pend_mode_q <= ModeRing;
      out_q       <= WIDTH'(pat_seed(ModeRing, WIDTH));
      tick_q      <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      pend_q      <= pend_d;
      pend_mode_q <= pend_mode_d;
      out_q       <= out_d;
      tick_q      <= tick_d;
      wrap_q      <= wrap_d;
    end
  end

  assign bus.mode_req_ready = !pend_q;
  assign bus.out            = out_q;
  assign bus.state          = state_q;
  assign bus.tick           = tick_q;
  assign bus.wrap           = wrap_q;
endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with WIDTH=4, DIV_MAX=3.
// Reverse-direction vectors run only when COUNTER_SEQ_REVERSE_EN is defined.
module tb_counter_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  counter_sequencer_if #(.WIDTH(4)) bus ();

  counter_sequencer #(
    .WIDTH   (4),
    .DIV_MAX (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {stop, start, step} held for one cycle.
  task automatic pulse(input logic [2:0] sss);
    {bus.stop, bus.start, bus.step} = sss;
    @(negedge clk);
    {bus.stop, bus.start, bus.step} = 3'b000;
  endtask

  task automatic req_mode(input logic [1:0] m);
    bus.mode_req       = m;
    bus.mode_req_valid = 1'b1;
    @(negedge clk);
    bus.mode_req_valid = 1'b0;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tick && n < 50);
    if (!bus.tick) check_eq("tick_timeout", 32'(bus.tick), 32'd1);
  endtask

  logic [3:0] ring_seq [0:3];
  logic [3:0] john_seq [0:7];
  logic [3:0] rrev_seq [0:3];

  initial begin
    int n;
    int bad;
    ring_seq = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
    john_seq = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    rrev_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    {bus.stop, bus.start, bus.step} = 3'b000;
    bus.mode_req       = 2'b00;
    bus.mode_req_valid = 1'b0;
`ifdef COUNTER_SEQ_REVERSE_EN
    bus.dir = 1'b0;
`endif

    // Reset values and ring run
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_out", 32'(bus.out), 32'h8);
    check_eq("rst_state", 32'(bus.state), 32'h0);
    check_eq("rst_ready", 32'(bus.mode_req_ready), 32'h1);
    check_eq("rst_tick", 32'(bus.tick), 32'h0);
    check_eq("rst_wrap", 32'(bus.wrap), 32'h0);
    pulse(3'b010);
    check_eq("run_state", 32'(bus.state), 32'h1);
    for (int i = 0; i < 4; i++) begin
      wait_tick(n);
      check_eq("ring_period", 32'(n), 32'd4);
      check_eq("ring_out", 32'(bus.out), 32'(ring_seq[i]));
      check_eq("ring_wrap", 32'(bus.wrap), (i == 3) ? 32'd1 : 32'd0);
    end

    // Johnson selected in IDLE
    pulse(3'b100);
    check_eq("pause_state", 32'(bus.state), 32'h2);
    pulse(3'b100);
    check_eq("idle_state", 32'(bus.state), 32'h0);
    check_eq("idle_seed", 32'(bus.out), 32'h8);
    req_mode(2'b01);
    check_eq("john_seed", 32'(bus.out), 32'h0);
    check_eq("john_ready", 32'(bus.mode_req_ready), 32'h1);
    pulse(3'b010);
    for (int i = 0; i < 8; i++) begin
      wait_tick(n);
      check_eq("john_out", 32'(bus.out), 32'(john_seq[i]));
      check_eq("john_wrap", 32'(bus.wrap), (i == 7) ? 32'd1 : 32'd0);
    end

    // Mode change requested in RUN is deferred to the wrap
    pulse(3'b100);
    pulse(3'b100);
    req_mode(2'b00);
    check_eq("ring_seed", 32'(bus.out), 32'h8);
    pulse(3'b010);
    wait_tick(n);
    check_eq("defer_out0", 32'(bus.out), 32'h4);
    req_mode(2'b10);
    check_eq("defer_ready0", 32'(bus.mode_req_ready), 32'h0);
    wait_tick(n);
    check_eq("defer_out1", 32'(bus.out), 32'h2);
    check_eq("defer_ready1", 32'(bus.mode_req_ready), 32'h0);
    wait_tick(n);
    check_eq("defer_out2", 32'(bus.out), 32'h1);
    check_eq("defer_ready2", 32'(bus.mode_req_ready), 32'h0);
    wait_tick(n);
    check_eq("defer_out3", 32'(bus.out), 32'h0);
    check_eq("defer_wrap3", 32'(bus.wrap), 32'h1);
    check_eq("defer_ready3", 32'(bus.mode_req_ready), 32'h1);
    wait_tick(n);
    check_eq("defer_out4", 32'(bus.out), 32'h1);
    check_eq("defer_wrap4", 32'(bus.wrap), 32'h0);

    // PAUSE holds, step advances once, stop returns to seed
    pulse(3'b100);
    check_eq("p_state", 32'(bus.state), 32'h2);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out !== 4'h1 || bus.tick !== 1'b0) bad++;
    end
    check_eq("pause_hold", 32'(bad), 32'd0);
    pulse(3'b001);
    check_eq("step_out", 32'(bus.out), 32'h2);
    check_eq("step_tick", 32'(bus.tick), 32'h1);
    @(negedge clk);
    check_eq("step_tick_off", 32'(bus.tick), 32'h0);
    check_eq("step_hold", 32'(bus.out), 32'h2);
    pulse(3'b100);
    check_eq("stop_idle", 32'(bus.state), 32'h0);
    check_eq("stop_seed", 32'(bus.out), 32'h0);
    check_eq("stop_nowrap", 32'(bus.wrap), 32'h0);

    // Priority, reserved mode, pending across PAUSE, reset mid-RUN
    pulse(3'b010);
    pulse(3'b110);
    check_eq("prio_state", 32'(bus.state), 32'h2);
    req_mode(2'b11);
    check_eq("rsvd_ready", 32'(bus.mode_req_ready), 32'h1);
    check_eq("rsvd_out", 32'(bus.out), 32'h0);
    pulse(3'b001);
    check_eq("rsvd_mode_kept", 32'(bus.out), 32'h1);
    pulse(3'b010);
    req_mode(2'b01);
    check_eq("pend_ready", 32'(bus.mode_req_ready), 32'h0);
    pulse(3'b100);
    check_eq("pend_pause", 32'(bus.state), 32'h2);
    check_eq("pend_still", 32'(bus.mode_req_ready), 32'h0);
    check_eq("pend_out_held", 32'(bus.out), 32'h1);
    @(negedge clk);
    check_eq("pend_applied", 32'(bus.out), 32'h0);
    check_eq("pend_ready1", 32'(bus.mode_req_ready), 32'h1);
    pulse(3'b001);
    check_eq("pend_john", 32'(bus.out), 32'h8);
    pulse(3'b010);
    req_mode(2'b00);
    check_eq("rst_pend_ready", 32'(bus.mode_req_ready), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rr_out", 32'(bus.out), 32'h8);
    check_eq("rr_state", 32'(bus.state), 32'h0);
    check_eq("rr_ready", 32'(bus.mode_req_ready), 32'h1);
    check_eq("rr_tick", 32'(bus.tick), 32'h0);
    check_eq("rr_wrap", 32'(bus.wrap), 32'h0);
    rst = 1'b0;
    @(negedge clk);

`ifdef COUNTER_SEQ_REVERSE_EN
    bus.dir = 1'b1;
    pulse(3'b010);
    for (int i = 0; i < 4; i++) begin
      wait_tick(n);
      check_eq("rev_ring_out", 32'(bus.out), 32'(rrev_seq[i]));
      check_eq("rev_ring_wrap", 32'(bus.wrap), (i == 3) ? 32'd1 : 32'd0);
    end
    pulse(3'b100);
    pulse(3'b100);
    req_mode(2'b10);
    check_eq("rev_bin_seed", 32'(bus.out), 32'h0);
    pulse(3'b001);
    check_eq("rev_bin_out", 32'(bus.out), 32'hF);
    bus.dir = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
